// File: rtl/bist_pkg.sv
// Shared types and constants for the full-adder BIST datapath.
// Holds the output-response-analyser state enum and the MISR feedback step.
package bist_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPACT = 2'd1,
      COMPARE = 2'd2,
      DONE    = 2'd3
   } ora_state_t;

   // Feedback taps for x^4+x+1: s4 folds back into stages 1 and 2.
   localparam logic [3:0] MISR_TAPS       = 4'b0011;
   localparam logic [3:0] ORA_GOLDEN_FA   = 4'b1011;
   localparam int         ORA_PATTERNS_FA = 8;

   // Bit 0 of s is stage s1, bit 3 is s4; r[1]=cout enters stage 2, r[0]=sum stage 1.
   function automatic logic [3:0] misr_next(input logic [3:0] s, input logic [1:0] r);
      logic [3:0] n;
      n = {s[2:0], 1'b0} ^ (MISR_TAPS & {4{s[3]}}) ^ {2'b00, r};
      return n;
   endfunction

endpackage

// File: rtl/misr_reg.sv
// 4-bit multiple-input signature register with synchronous seed load and enable.
// Load has priority over enable so a restart never compacts the coincident response.
module misr_reg
   import bist_pkg::*;
#(
   parameter int               SIG_W = 4,
   parameter logic [SIG_W-1:0] SEED  = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [1:0]       resp,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_d;
   logic [SIG_W-1:0] sig_q;

   always_comb begin
      sig_d = sig_q;
      if (load) begin
         sig_d = SEED;
      end else if (en) begin
         sig_d = misr_next(sig_q, resp);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sig_q <= SEED;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/bist_misr_ora.sv
// Output response analyser: compacts CUT responses into a MISR and judges the signature.
// Define ORA_STICKY_FAULT_EN to keep fault_detected set until reset.
module bist_misr_ora
   import bist_pkg::*;
#(
   parameter int               SIG_W    = 4,
   parameter int               PATTERNS = ORA_PATTERNS_FA,
   parameter logic [SIG_W-1:0] SEED     = '0,
   parameter logic [SIG_W-1:0] GOLDEN   = ORA_GOLDEN_FA
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           testmode,
   input  logic           start,
   // resp is consumed on every rising edge where resp_valid=1 in COMPACT; no back-pressure.
   input  logic           resp_valid,
   input  logic [1:0]     resp,
   output logic [SIG_W:1] dataout_ora,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic           fault_detected,
   output ora_state_t     state_dbg
);

   localparam int CNT_W = $clog2(PATTERNS) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATTERNS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

`ifdef ORA_STICKY_FAULT_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   ora_state_t       state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             pass_d, pass_q;
   logic             fault_d, fault_q;
   logic             misr_load;
   logic             misr_en;
   logic [SIG_W-1:0] sig;
   logic             sig_match;

   assign sig_match = (sig == GOLDEN);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pass_d    = pass_q;
      fault_d   = fault_q;
      misr_load = 1'b0;
      misr_en   = 1'b0;
      if (state_q != IDLE && !testmode) begin
         state_d = IDLE;
         pass_d  = 1'b0;
         fault_d = STICKY ? fault_q : 1'b0;
      end else if (testmode && start) begin
         // Restart from any state; start beats a coincident resp_valid.
         state_d   = COMPACT;
         misr_load = 1'b1;
         cnt_d     = '0;
         pass_d    = 1'b0;
         fault_d   = STICKY ? fault_q : 1'b0;
      end else begin
         case (state_q)
            COMPACT: begin
               if (resp_valid) begin
                  misr_en = 1'b1;
                  if (cnt_q != CNT_MAX) begin
                     cnt_d = cnt_q + 1'b1;
                  end
                  if (cnt_q == CNT_LAST) begin
                     state_d = COMPARE;
                  end
               end
            end
            COMPARE: begin
               pass_d  = sig_match;
               fault_d = STICKY ? (fault_q | ~sig_match) : ~sig_match;
               state_d = DONE;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
         fault_q <= fault_d;
      end
   end

   misr_reg #(
      .SIG_W (SIG_W),
      .SEED  (SEED)
   ) u_misr (
      .clock (clock),
      .reset (reset),
      .load  (misr_load),
      .en    (misr_en),
      .resp  (resp),
      .sig   (sig)
   );

   assign dataout_ora    = sig;
   assign busy           = (state_q == COMPACT) || (state_q == COMPARE);
   assign done           = (state_q == DONE);
   assign pass           = pass_q;
   assign fault_detected = fault_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_bist_misr_ora.sv
// Bench for bist_misr_ora: polynomial-arithmetic reference model, per-cycle compare,
// verdict scoreboard, directed windows from the test plan plus randomized traffic.
module tb_bist_misr_ora;
   import bist_pkg::*;

   logic       clock      = 1'b0;
   logic       reset      = 1'b1;
   logic       testmode   = 1'b0;
   logic       start      = 1'b0;
   logic       resp_valid = 1'b0;
   logic [1:0] resp       = 2'b00;

   logic [4:1] dataout_ora;
   logic       busy, done, pass, fault_detected;
   ora_state_t state_dbg;

   int checks   = 0;
   int failures = 0;

`ifdef ORA_STICKY_FAULT_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   // responses listed first-to-last from bit 1:0 upward
   localparam logic [15:0] SWEEP_OK  = 16'b11_10_10_01_10_01_01_00;
   localparam logic [15:0] SWEEP_SA0 = 16'b10_10_10_00_10_00_00_00;

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   bist_misr_ora dut (
      .clock          (clock),
      .reset          (reset),
      .testmode       (testmode),
      .start          (start),
      .resp_valid     (resp_valid),
      .resp           (resp),
      .dataout_ora    (dataout_ora),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .fault_detected (fault_detected),
      .state_dbg      (state_dbg)
   );

   task automatic check_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_v(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Signature as a GF(2) polynomial: multiply by x modulo x^4+x+1, then add the response.
   function automatic logic [3:0] gf_step(input logic [3:0] s, input logic [1:0] r);
      int v;
      v = int'(s) * 2;
      if (v >= 16) v = (v - 16) ^ 3;
      return 4'(v) ^ {2'b00, r};
   endfunction

   localparam int M_IDLE = 0, M_COLLECT = 1, M_JUDGE = 2, M_VERDICT = 3;
   int         m_phase = M_IDLE;
   int         m_n     = 0;
   logic [3:0] m_sig   = 4'b0000;
   logic       m_done  = 1'b0;
   logic       m_pass  = 1'b0;
   logic       m_fault = 1'b0;
   logic [1:0] win_q[$];
   logic [3:0] exp_q[$];

   always @(posedge clock or posedge reset) begin : model_blk
      logic [3:0] fold;
      if (reset) begin
         m_phase = M_IDLE; m_n = 0; m_sig = 4'b0000;
         m_done = 1'b0; m_pass = 1'b0; m_fault = 1'b0;
         win_q.delete();
         exp_q.delete();
      end else if (!testmode) begin
         if (m_phase != M_IDLE) begin
            m_phase = M_IDLE; m_done = 1'b0; m_pass = 1'b0;
            if (!STICKY) m_fault = 1'b0;
         end
      end else if (start) begin
         m_phase = M_COLLECT; m_n = 0; m_sig = 4'b0000;
         m_done = 1'b0; m_pass = 1'b0;
         if (!STICKY) m_fault = 1'b0;
         win_q.delete();
      end else if (m_phase == M_COLLECT) begin
         if (resp_valid) begin
            m_sig = gf_step(m_sig, resp);
            m_n++;
            win_q.push_back(resp);
            if (m_n == 8) m_phase = M_JUDGE;
         end
      end else if (m_phase == M_JUDGE) begin
         fold = 4'b0000;
         foreach (win_q[i]) fold = gf_step(fold, win_q[i]);
         exp_q.push_back(fold);
         m_pass  = (m_sig == 4'b1011);
         m_fault = STICKY ? (m_fault | !m_pass) : !m_pass;
         m_done  = 1'b1;
         m_phase = M_VERDICT;
      end
   end

   // ---------------- per-cycle compare + verdict scoreboard ----------------
   logic prev_done = 1'b0;
   always @(posedge clock) begin
      #1;
      check_v("sig", dataout_ora, m_sig);
      check_b("busy", busy, m_phase == M_COLLECT || m_phase == M_JUDGE);
      check_b("done", done, m_done);
      if (m_done) check_b("pass", pass, m_pass);
      check_b("fault", fault_detected, m_fault);
      check_b("idle_state", state_dbg == IDLE, m_phase == M_IDLE);
      if (done && !prev_done) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL verdict_unexpected: done rose with sig=%b, no window expected", dataout_ora);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (dataout_ora !== e) begin
               failures++;
               $display("FAIL verdict_sig: actual=%b expected=%b", dataout_ora, e);
            end
         end
      end
      prev_done = done;
   end

   // ---------------- driver tasks ----------------
   // Inputs change just after a falling edge and hold through the next rising edge.
   task automatic cyc(input logic tm, input logic st, input logic v, input logic [1:0] r);
      testmode = tm; start = st; resp_valid = v; resp = r;
      @(negedge clock);
   endtask

   task automatic feed(input logic [1:0] r, input int min_gap, input int max_gap);
      repeat ($urandom_range(min_gap, max_gap)) cyc(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
      cyc(1'b1, 1'b0, 1'b1, r);
   endtask

   task automatic run_window(input logic [15:0] p, input int min_gap, input int max_gap);
      cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      for (int i = 0; i < 8; i++) feed(p[2*i +: 2], min_gap, max_gap);
      check_b("win_done_early", done, 1'b0);
      check_b("win_busy_compare", busy, 1'b1);
      cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      check_b("win_done_latency", done, 1'b1);
      check_b("win_busy_cleared", busy, 1'b0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      @(negedge clock);
      check_v("rst_sig", dataout_ora, 4'b0000);
      check_b("rst_busy", busy, 1'b0);
      check_b("rst_done", done, 1'b0);
      check_b("rst_pass", pass, 1'b0);
      check_b("rst_fault", fault_detected, 1'b0);
      check_b("rst_idle", state_dbg == IDLE, 1'b1);
      reset = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 2'b00);

      // fault-free back-to-back sweep
      run_window(SWEEP_OK, 0, 0);
      check_v("ok_sig", dataout_ora, 4'b1011);
      check_b("ok_pass", pass, 1'b1);
      check_b("ok_fault", fault_detected, 1'b0);
      repeat (3) cyc(1'b1, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
      check_b("ok_done_level", done, 1'b1);
      check_v("ok_sig_held", dataout_ora, 4'b1011);

      // sum stuck-at-0
      run_window(SWEEP_SA0, 0, 0);
      check_v("sa0_sig", dataout_ora, 4'b1000);
      check_b("sa0_pass", pass, 1'b0);
      check_b("sa0_fault", fault_detected, 1'b1);

      // fault-free after faulty, with gaps: stickiness decides fault_detected
      run_window(SWEEP_OK, 1, 3);
      check_v("gap_sig", dataout_ora, 4'b1011);
      check_b("gap_pass", pass, 1'b1);
      check_b("sticky_fault", fault_detected, STICKY);

      // abort after 4 responses, then recover
      run_window(SWEEP_SA0, 0, 0);
      cyc(1'b1, 1'b1, 1'b0, 2'b00);
      for (int i = 0; i < 4; i++) feed(SWEEP_OK[2*i +: 2], 0, 1);
      cyc(1'b0, 1'b0, 1'b1, 2'b11);
      check_b("abort_busy", busy, 1'b0);
      check_b("abort_done", done, 1'b0);
      check_b("abort_idle", state_dbg == IDLE, 1'b1);
      check_v("abort_sig_hold", dataout_ora, 4'b0100);
      check_b("abort_fault", fault_detected, STICKY);
      cyc(1'b0, 1'b1, 1'b1, 2'b01);
      check_b("abort_start_ignored", busy, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 2'b00);
      run_window(SWEEP_OK, 0, 2);
      check_b("recover_pass", pass, 1'b1);

      // restart during COMPACT, then during COMPARE
      cyc(1'b1, 1'b1, 1'b0, 2'b00);
      for (int i = 0; i < 3; i++) feed(SWEEP_SA0[2*i +: 2], 0, 1);
      run_window(SWEEP_OK, 0, 1);
      check_v("restart_compact_sig", dataout_ora, 4'b1011);
      cyc(1'b1, 1'b1, 1'b0, 2'b00);
      for (int i = 0; i < 8; i++) feed(SWEEP_SA0[2*i +: 2], 0, 0);
      run_window(SWEEP_OK, 0, 0);
      check_b("restart_compare_pass", pass, 1'b1);

      // asynchronous reset mid-window, between edges
      cyc(1'b1, 1'b1, 1'b0, 2'b00);
      for (int i = 0; i < 3; i++) feed(SWEEP_OK[2*i +: 2], 0, 0);
      #2 reset = 1'b1;
      #1;
      check_v("areset_sig", dataout_ora, 4'b0000);
      check_b("areset_busy", busy, 1'b0);
      check_b("areset_done", done, 1'b0);
      check_b("areset_fault", fault_detected, 1'b0);
      check_b("areset_idle", state_dbg == IDLE, 1'b1);
      @(negedge clock);
      reset = 1'b0;
      cyc(1'b1, 1'b0, 1'b1, 2'b10);
      check_b("post_reset_idle", state_dbg == IDLE, 1'b1);

      // random windows, then free-running random traffic
      repeat (6) run_window(16'($urandom_range(0, 65535)), 0, 2);
      repeat (600) cyc($urandom_range(0, 24) != 0, $urandom_range(0, 14) == 0,
                       $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
      cyc(1'b1, 1'b0, 1'b0, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
